// File: rtl/spike_synapse_if.sv
// Spike-synapse bus: timestep strobe, presynaptic spikes, weight programming
// port and the current/status outputs toward the neuron.
interface spike_synapse_if #(
  parameter int N       = 4,
  parameter int W_WIDTH = 8
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;

  logic                      tick;
  logic [N-1:0]              spike_in;
  logic                      wr_en;
  logic [AW-1:0]             wr_addr;
  logic signed [W_WIDTH-1:0] wr_data;
  logic [15:0]               I_out;
  logic                      out_valid;
  logic                      busy;
  logic                      overrun;

  modport master (
    output tick, spike_in, wr_en, wr_addr, wr_data,
    input  I_out, out_valid, busy, overrun
  );

  modport slave (
    input  tick, spike_in, wr_en, wr_addr, wr_data,
    output I_out, out_valid, busy, overrun
  );
endinterface

// File: rtl/spike_synapse.sv
// Current-based synaptic integrator. On each accepted tick the current decays
// by I >> DECAY_SHIFT, then each spiking line adds its signed weight, one line
// per cycle, saturating to 0..65535 after every add.
module spike_synapse #(
  parameter int N           = 4,
  parameter int DECAY_SHIFT = 3,
  parameter int W_WIDTH     = 8
) (
  input logic            clk,
  input logic            reset,
  spike_synapse_if.slave bus
);
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                    state_q, state_d;
  logic [AW-1:0]             idx_q, idx_d;
  logic [N-1:0]              spike_lat_q, spike_lat_d;
  logic [15:0]               i_acc_q, i_acc_d;
  logic [15:0]               i_out_q, i_out_d;
  logic                      out_valid_q, out_valid_d;
  logic                      busy_q, busy_d;
  logic                      overrun_q, overrun_d;
  logic signed [W_WIDTH-1:0] weight_q [N];
  logic signed [W_WIDTH-1:0] weight_d [N];
  logic                      addr_ok_s;

  // Add a signed weight to the unsigned current in 18-bit signed space and
  // saturate the result back into the 16-bit unsigned range.
  function automatic logic [15:0] clamp_add(input logic [15:0] acc,
                                            input logic signed [W_WIDTH-1:0] w);
    logic signed [17:0] sum;
    sum = $signed({2'b00, acc}) + $signed({{(18-W_WIDTH){w[W_WIDTH-1]}}, w});
    if (sum < 18'sd0) begin
      clamp_add = 16'd0;
    end else if (sum > 18'sd65535) begin
      clamp_add = 16'hFFFF;
    end else begin
      clamp_add = sum[15:0];
    end
  endfunction

  // Out-of-range write addresses only exist when N is not a power of two.
  generate
    if (N == (1 << AW)) begin : g_addr_full
      assign addr_ok_s = 1'b1;
    end else begin : g_addr_part
      assign addr_ok_s = ({{(32-AW){1'b0}}, bus.wr_addr} < 32'(N));
    end
  endgenerate

  // Next-state logic: weight writes, timestep sequencing and overrun tracking.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    spike_lat_d = spike_lat_q;
    i_acc_d     = i_acc_q;
    i_out_d     = i_out_q;
    out_valid_d = 1'b0;
    busy_d      = busy_q;
    overrun_d   = overrun_q;
    weight_d    = weight_q;

    // A write lands at the edge; an ACCUM read at the same edge sees weight_q.
    if (bus.wr_en && addr_ok_s) begin
      weight_d[bus.wr_addr] = bus.wr_data;
    end else begin
      weight_d = weight_q;
    end

    case (state_q)
      IDLE: begin
        if (bus.tick) begin
          spike_lat_d = bus.spike_in;
          i_acc_d     = i_acc_q - (i_acc_q >> DECAY_SHIFT);
          idx_d       = '0;
          busy_d      = 1'b1;
          state_d     = ACCUM;
        end else begin
          state_d = IDLE;
        end
      end
      ACCUM: begin
        if (spike_lat_q[idx_q]) begin
          i_acc_d = clamp_add(i_acc_q, weight_q[idx_q]);
        end else begin
          i_acc_d = i_acc_q;
        end
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
        end else begin
          idx_d = idx_q + AW'(1);
        end
        if (bus.tick) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end
      DONE: begin
        i_out_d     = i_acc_q;
        out_valid_d = 1'b1;
        busy_d      = 1'b0;
        state_d     = IDLE;
        if (bus.tick) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset also clears the weight table.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      spike_lat_q <= '0;
      i_acc_q     <= 16'd0;
      i_out_q     <= 16'd0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
      for (int i = 0; i < N; i++) begin
        weight_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      spike_lat_q <= spike_lat_d;
      i_acc_q     <= i_acc_d;
      i_out_q     <= i_out_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
      for (int i = 0; i < N; i++) begin
        weight_q[i] <= weight_d[i];
      end
    end
  end

  assign bus.I_out     = i_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;
  assign bus.overrun   = overrun_q;
endmodule

// File: tb/tb_spike_synapse.sv
// Bench for spike_synapse: two instances (decay shift 3 and 15) see identical
// stimulus and are compared against an arithmetic model of the synapse.
module tb_spike_synapse;
  localparam int N = 4;

  logic              clk;
  logic              reset;
  logic              tick;
  logic [N-1:0]      spike_in;
  logic              wr_en;
  logic [1:0]        wr_addr;
  logic signed [7:0] wr_data;

  int vectors;
  int miscompares;

  // model state: index 0 -> shift 3 instance, index 1 -> shift 15 instance
  int m_i [2];
  int m_w [N];
  bit m_ovr;

  spike_synapse_if #(.N(N), .W_WIDTH(8)) if_a ();
  spike_synapse_if #(.N(N), .W_WIDTH(8)) if_b ();

  assign if_a.tick = tick;     assign if_b.tick = tick;
  assign if_a.spike_in = spike_in; assign if_b.spike_in = spike_in;
  assign if_a.wr_en = wr_en;   assign if_b.wr_en = wr_en;
  assign if_a.wr_addr = wr_addr; assign if_b.wr_addr = wr_addr;
  assign if_a.wr_data = wr_data; assign if_b.wr_data = wr_data;

  spike_synapse #(.N(N), .DECAY_SHIFT(3), .W_WIDTH(8)) u_a (
    .clk(clk), .reset(reset), .bus(if_a.slave));
  spike_synapse #(.N(N), .DECAY_SHIFT(15), .W_WIDTH(8)) u_b (
    .clk(clk), .reset(reset), .bus(if_b.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clampi(input int v);
    if (v < 0) return 0;
    if (v > 65535) return 65535;
    return v;
  endfunction

  // one timestep of the reference: truncating decay, then ordered clamped adds
  task automatic model_step(input logic [N-1:0] sp);
    for (int k = 0; k < 2; k++) begin
      int ds;
      ds = (k == 0) ? 3 : 15;
      m_i[k] = m_i[k] - (m_i[k] >> ds);
      for (int i = 0; i < N; i++)
        if (sp[i]) m_i[k] = clampi(m_i[k] + m_w[i]);
    end
  endtask

  task automatic write_w(input int a, input int d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a[1:0]; wr_data = d[7:0];
    @(negedge clk);
    wr_en = 1'b0;
    m_w[a] = d;
  endtask

  // One timestep. ovr: second tick pulse at E0+2. col: write w3=col_d at
  // the edge that processes index 3.
  task automatic run_tick(input logic [N-1:0] sp, input bit ovr, input bit col, input int col_d);
    int cyc;
    bit got;
    @(negedge clk);
    tick = 1'b1; spike_in = sp;
    @(posedge clk);
    #1;
    check(32'(if_a.busy), 32'd1, "busy_at_e0");
    check(32'(if_a.out_valid), 32'd0, "valid_low_at_e0");
    cyc = 0; got = 1'b0;
    for (int c = 1; c <= N + 4 && !got; c++) begin
      @(negedge clk);
      tick = (ovr && c == 2);
      spike_in = N'($urandom);
      wr_en = 1'b0;
      if (col && c == N) begin
        wr_en = 1'b1; wr_addr = 2'd3; wr_data = col_d[7:0];
      end
      @(posedge clk);
      #1;
      if (if_a.out_valid) begin
        got = 1'b1; cyc = c;
      end else begin
        check(32'(if_a.busy), 32'd1, "busy_during");
      end
    end
    @(negedge clk);
    wr_en = 1'b0; tick = 1'b0;
    check(32'(cyc), 32'(N + 1), "latency");
    check(32'(if_a.busy), 32'd0, "busy_after");
    check(32'(if_b.out_valid), 32'd1, "valid_b");
    model_step(sp);
    if (col) m_w[3] = col_d;
    if (ovr) m_ovr = 1'b1;
    check(32'(if_a.I_out), 32'(m_i[0]), "iout_a");
    check(32'(if_b.I_out), 32'(m_i[1]), "iout_b");
    check(32'(if_a.overrun), 32'(m_ovr), "overrun_a");
  endtask

  initial begin
    int prev_b;
    vectors = 0; miscompares = 0;
    m_i[0] = 0; m_i[1] = 0; m_ovr = 1'b0;
    for (int i = 0; i < N; i++) m_w[i] = 0;
    reset = 1'b1; tick = 1'b0; spike_in = '0; wr_en = 1'b0; wr_addr = 2'd0; wr_data = 8'sd0;
    repeat (2) @(posedge clk);
    #1;
    check(32'(if_a.I_out), 32'd0, "rst_iout");
    check(32'(if_a.out_valid), 32'd0, "rst_valid");
    check(32'(if_a.busy), 32'd0, "rst_busy");
    check(32'(if_a.overrun), 32'd0, "rst_overrun");
    @(negedge clk);
    reset = 1'b0;

    // basic, latency and decay
    write_w(0, 100);
    run_tick(4'b0001, 1'b0, 1'b0, 0);
    check(32'(if_a.I_out), 32'd100, "basic_100");
    run_tick(4'b0000, 1'b0, 1'b0, 0);
    check(32'(if_a.I_out), 32'd88, "decay_88");
    run_tick(4'b0000, 1'b0, 1'b0, 0);
    check(32'(if_a.I_out), 32'd77, "decay_77");

    // inhibitory weight and clamp at zero
    write_w(1, -50);
    run_tick(4'b0010, 1'b0, 1'b0, 0);
    check(32'(if_a.I_out), 32'd18, "inhib_18");
    run_tick(4'b0010, 1'b0, 1'b0, 0);
    check(32'(if_a.I_out), 32'd0, "clamp_0");
    run_tick(4'b0011, 1'b0, 1'b0, 0);
    check(32'(if_a.I_out), 32'd50, "mixed_50");

    // write collision on index 3: old weight 5 used now, 20 next step
    write_w(3, 5);
    run_tick(4'b1000, 1'b0, 1'b1, 20);
    check(32'(if_a.I_out), 32'd49, "collide_old");
    run_tick(4'b1000, 1'b0, 1'b0, 0);
    check(32'(if_a.I_out), 32'd63, "collide_new");

    // overrun: second tick while busy is ignored, flag is sticky
    run_tick(4'b0001, 1'b1, 1'b0, 0);
    check(32'(if_a.overrun), 32'd1, "overrun_set");
    repeat (N + 2) begin
      @(posedge clk);
      #1;
      check(32'(if_a.out_valid) + 32'(if_a.busy), 32'd0, "no_second_update");
    end
    run_tick(4'b0100, 1'b0, 1'b0, 0);

    // randomized weights and spikes, back-to-back ticks
    for (int r = 0; r < 20; r++) begin
      if ($urandom_range(1) == 1) write_w(int'($urandom_range(N - 1)), int'($urandom_range(255)) - 128);
      run_tick(N'($urandom), 1'b0, 1'b0, 0);
    end

    // saturation: shift-15 instance must climb to 65535 and stay there
    for (int i = 0; i < N; i++) write_w(i, 127);
    prev_b = int'(if_b.I_out);
    for (int r = 0; r < 135; r++) begin
      run_tick(4'b1111, 1'b0, 1'b0, 0);
      check(32'(int'(if_b.I_out) >= prev_b), 32'd1, "no_wrap");
      prev_b = int'(if_b.I_out);
    end
    check(32'(if_b.I_out), 32'd65535, "saturated");

    // reset in the middle of an update
    @(negedge clk);
    tick = 1'b1; spike_in = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    tick = 1'b0;
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check(32'(if_b.I_out), 32'd0, "midrst_iout");
    check(32'(if_a.out_valid), 32'd0, "midrst_valid");
    check(32'(if_a.busy), 32'd0, "midrst_busy");
    check(32'(if_a.overrun), 32'd0, "midrst_overrun");
    @(negedge clk);
    reset = 1'b0;
    m_i[0] = 0; m_i[1] = 0; m_ovr = 1'b0;
    for (int i = 0; i < N; i++) m_w[i] = 0;
    run_tick(4'b1111, 1'b0, 1'b0, 0);
    check(32'(if_a.I_out), 32'd0, "weights_cleared");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/spike_synapse.md
Name: spike_synapse

Overview:
- Current-based synaptic integrator: the receive end of the spike interface.
- Takes N presynaptic spike lines once per timestep and applies a programmable signed weight per line.
- Keeps an exponentially decaying synaptic current and drives it as a 16-bit unsigned current into a LIF neuron's current input.
- One update per timestep `tick`, processed serially, one synapse per cycle.

Parameters:
- N, 4: number of presynaptic spike inputs (2..16).
- DECAY_SHIFT, 3: per-timestep decay is I - (I >> DECAY_SHIFT); legal range 1..15.
- W_WIDTH, 8: signed weight width (two's complement).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  timestep strobe; starts one update when sampled in IDLE.
- spike_in  in  N  presynaptic spikes; sampled only on the accepted tick edge.
- wr_en  in  1  weight write enable.
- wr_addr  in  clog2(N)  weight index.
- wr_data  in  W_WIDTH  signed weight value.
- I_out  out  16  synaptic current to the neuron (unsigned).
- out_valid  out  1  one-cycle pulse; I_out was updated at the same edge.
- busy  out  1  high while an update is in progress.
- overrun  out  1  sticky; set when tick arrives while busy.

Behaviour:
- Reset (async, immediate) clears:
  - I_acc=0, I_out=0, out_valid=0, busy=0, overrun=0.
  - All weights=0, state=IDLE.
- State machine: IDLE -> ACCUM -> DONE -> IDLE.
- IDLE, tick=1 at edge E0:
  - spike_lat <= spike_in.
  - I_acc <= I_acc - (I_acc >> DECAY_SHIFT).
  - idx <= 0, busy <= 1, state <= ACCUM.
- IDLE, tick=0: hold all state; out_valid=0.
- ACCUM, one edge per index idx = 0..N-1:
  - If spike_lat[idx], I_acc <= clamp(I_acc + sext(weight[idx]), 0, 65535).
  - Arithmetic is in 18-bit signed; the clamp is applied after every add, not once at the end.
  - Skipped lines leave I_acc unchanged.
  - At idx=N-1: state <= DONE.
- DONE edge:
  - I_out <= I_acc, out_valid <= 1, busy <= 0, state <= IDLE.
  - out_valid drops at the next edge.
- Latency:
  - out_valid and the new I_out are visible after edge E0+N+1.
  - busy is high for exactly N+1 cycles.
- Back-to-back operation: a tick sampled in the cycle after DONE (state IDLE) is accepted normally. Minimum tick period is N+2 cycles.
- tick while busy (ACCUM or DONE):
  - Ignored; does not alter state, spike_lat or I_acc.
  - overrun <= 1. Only reset clears overrun.
- Decay uses truncating shift. Examples:
  - 7 with shift 3 -> 7.
  - 8 -> 7.
  - 0 stays 0.
- I_out holds its value between updates; it changes only at DONE.
- Weight writes:
  - Accepted in any state. wr_en at an edge updates weight[wr_addr] at that edge.
  - An ACCUM read of the same index at the same edge uses the old value.
  - Writes to indices already processed affect only the next timestep.
  - wr_addr >= N is ignored.
- spike_in changes after E0 have no effect on the current update.
- Reset mid-ACCUM/DONE:
  - Abort immediately, no out_valid pulse.
  - All state returns to reset values, including weights.

Test Plan:
- Reset: assert reset mid-run -> I_out=0, out_valid=0, busy=0, overrun=0 immediately; after release, tick with spike_in=4'b1111 -> I_out=0 (weights cleared).
- Basic/latency/decay (N=4, DECAY_SHIFT=3):
  - Write w0=100, tick with spike_in=4'b0001 -> out_valid exactly 5 edges after the tick edge, I_out=100, busy high for 5 cycles.
  - Two empty ticks -> I_out=88, then 77.
- Inhibitory/clamp:
  - w1=-50, from I=77, spike_in=4'b0010 -> 68-50=18.
  - Repeat -> 16-50 clamps to I_out=0.
  - Mixed w0=100 and w1=-50 with both spikes from 0 -> I_out=50 (per-add clamp; index order 0 then 1).
- Saturation (DECAY_SHIFT=15): all weights 127, spike_in=4'b1111 every tick -> I_out rises 508 per tick (minus decay), reaches 65535 and holds there, never wraps.
- Overrun: tick pulsed at E0 and again at E0+2 -> exactly one out_valid, overrun=1 sticky; the next tick sampled in IDLE is accepted normally.
- Write collision: during ACCUM write w3=20 at the edge idx=3 is processed with old w3=5 and spike_in[3]=1 -> this step adds 5; the next step adds 20.
